// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, branch classification and field layout for the ID stage.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;

  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;

  // Control-transfer class of the instruction in IF/ID
  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_J,
    BR_JR
  } br_kind_e;

  // I-type field view of an instruction word
  typedef struct packed {
    logic [5:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [15:0]      imm;
  } itype_t;

  // Classify an instruction word; j and jal share the same target form
  function automatic br_kind_e decode_br(logic [XLEN-1:0] instr);
    br_kind_e k;
    k = BR_NONE;
    case (instr[31:26])
      OP_BEQ:        k = BR_BEQ;
      OP_BNE:        k = BR_BNE;
      OP_J, OP_JAL:  k = BR_J;
      OP_SPECIAL:    k = (instr[5:0] == FN_JR) ? BR_JR : BR_NONE;
      default:       k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch <-> decode link: instruction/PC+4 in, stall and redirect controls back to fetch.
interface id_stage_if;
  import mips_pkg::*;

  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc4;
  logic            Stall;
  logic            Branch;
  logic            NPCsel;
  logic            CMPout;
  logic [XLEN-1:0] nextPC;

  modport master (output if_instr, if_pc4, input Stall, Branch, NPCsel, CMPout, nextPC);
  modport slave  (input if_instr, if_pc4, output Stall, Branch, NPCsel, CMPout, nextPC);
endinterface

// File: rtl/id_stage_npc_calc.sv
// Branch comparator and next-PC target selection for the instruction held in IF/ID.
module npc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] ir,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            cmp_out_c,
  output logic [XLEN-1:0] next_pc_c
);

  br_kind_e        kind;
  itype_t          fields;
  logic [XLEN-1:0] br_off;

  assign kind   = decode_br(ir);
  assign fields = itype_t'(ir);
  assign br_off = {{14{fields.imm[15]}}, fields.imm, 2'b00};

  // Compare operands and pick the target; conditional target is the default
  always_comb begin
    cmp_out_c = 1'b0;
    next_pc_c = pc4 + br_off;
    case (kind)
      BR_BEQ:  cmp_out_c = (rs_val == rt_val);
      BR_BNE:  cmp_out_c = (rs_val != rt_val);
      BR_J:    next_pc_c = {pc4[31:28], ir[25:0], 2'b00};
      BR_JR:   next_pc_c = rs_val;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// IF/ID register, decode-stage branch resolution and hazard detection.
// Optional feature macro: ID_FWD_EN (EX/MEM ALU result forwarded into decode operands).
module id_stage
  import mips_pkg::*;
#(
  parameter int unsigned     CNT_W = 16,
  parameter logic [31:0]     NOP   = mips_pkg::NOP
) (
  input  logic             clk,
  input  logic             reset,
  id_stage_if.slave        fw,
  input  logic [XLEN-1:0]  rf_rs_data,
  input  logic [XLEN-1:0]  rf_rt_data,
  input  logic [REG_W-1:0] ex_wr_addr,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_wr_addr,
  input  logic             mem_wr_en,
  input  logic             mem_is_load,
  input  logic [XLEN-1:0]  mem_wr_data,
  output logic [REG_W-1:0] rs_addr,
  output logic [REG_W-1:0] rt_addr,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc4,
  output logic [XLEN-1:0]  id_rs_val,
  output logic [XLEN-1:0]  id_rt_val,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [XLEN-1:0]  ir;
  logic [XLEN-1:0]  pc4;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall;
  br_kind_e         kind;
  itype_t           fields;

  logic early_rs, early_rt, late_rs, late_rt;
  logic use_rs, use_rt;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic haz_rs, haz_rt, fwd_rs, fwd_rt;

  assign kind    = decode_br(ir);
  assign fields  = itype_t'(ir);
  assign rs_addr = fields.rs;
  assign rt_addr = fields.rt;

  // Branches compare in decode, so their sources are needed a stage earlier than ALU/mem sources
  assign early_rs = (kind == BR_BEQ) || (kind == BR_BNE) || (kind == BR_JR);
  assign early_rt = (kind == BR_BEQ) || (kind == BR_BNE);
  assign late_rs  = (kind == BR_NONE);
  assign late_rt  = (kind == BR_NONE) && ((fields.op == OP_SPECIAL) || (fields.op[5:3] == 3'b101));
  assign use_rs   = early_rs || late_rs;
  assign use_rt   = early_rt || late_rt;

  // Producer matches; register $0 never matches
  assign ex_hit_rs  = ex_wr_en  && (ex_wr_addr  == fields.rs) && (fields.rs != '0);
  assign ex_hit_rt  = ex_wr_en  && (ex_wr_addr  == fields.rt) && (fields.rt != '0);
  assign mem_hit_rs = mem_wr_en && (mem_wr_addr == fields.rs) && (fields.rs != '0);
  assign mem_hit_rt = mem_wr_en && (mem_wr_addr == fields.rt) && (fields.rt != '0);

`ifdef ID_FWD_EN
  // Load in EX blocks any use; branch sources also wait on any EX result and on a load in MEM
  assign haz_rs = use_rs && ((ex_hit_rs && ex_is_load) || (early_rs && ex_hit_rs) ||
                             (early_rs && mem_hit_rs && mem_is_load));
  assign haz_rt = use_rt && ((ex_hit_rt && ex_is_load) || (early_rt && ex_hit_rt) ||
                             (early_rt && mem_hit_rt && mem_is_load));
  assign fwd_rs = mem_hit_rs && !mem_is_load;
  assign fwd_rt = mem_hit_rt && !mem_is_load;
`else
  // Without forwarding every in-flight write to a source must drain first
  logic unused_load_flags;
  assign unused_load_flags = ex_is_load ^ mem_is_load;
  assign haz_rs = use_rs && (ex_hit_rs || mem_hit_rs);
  assign haz_rt = use_rt && (ex_hit_rt || mem_hit_rt);
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif

  assign stall = haz_rs || haz_rt;

  assign id_rs_val = (fields.rs == '0) ? '0 : (fwd_rs ? mem_wr_data : rf_rs_data);
  assign id_rt_val = (fields.rt == '0) ? '0 : (fwd_rt ? mem_wr_data : rf_rt_data);

  // IF/ID register; held while stalled, never flushed so the delay slot always executes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir  <= NOP;
      pc4 <= '0;
    end else if (!stall) begin
      ir  <= fw.if_instr;
      pc4 <= fw.if_pc4;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  npc_calc u_npc_calc (
    .ir        (ir),
    .pc4       (pc4),
    .rs_val    (id_rs_val),
    .rt_val    (id_rt_val),
    .cmp_out_c (fw.CMPout),
    .next_pc_c (fw.nextPC)
  );

  assign fw.Stall      = stall;
  assign fw.Branch     = (kind != BR_NONE);
  assign fw.NPCsel     = (kind == BR_J) || (kind == BR_JR);
  assign id_bubble     = stall;
  assign id_instr      = stall ? NOP : ir;
  assign id_pc4        = pc4;
  assign stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table plus stall, delay-slot, reset and saturation sequences.
module tb_id_stage;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [4:0]  ex_a;
    logic        ex_en;
    logic        ex_ld;
    logic [4:0]  mem_a;
    logic        mem_en;
    logic        mem_ld;
    logic [31:0] mem_d;
    logic        e_stall;
    logic        e_br;
    logic        e_nsel;
    logic        e_cmp;
    logic [31:0] e_npc;
    logic [31:0] e_rsv;
    logic [31:0] e_rtv;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] rf_rs_data, rf_rt_data, mem_wr_data;
  logic [4:0]  ex_wr_addr, mem_wr_addr;
  logic        ex_wr_en, ex_is_load, mem_wr_en, mem_is_load;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] id_instr, id_pc4, id_rs_val, id_rt_val;
  logic        id_bubble;
  logic [15:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vecs[15];
  vec_t exp_q[$];

  id_stage_if fw ();

  id_stage #(.CNT_W(16), .NOP(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .fw           (fw),
    .rf_rs_data   (rf_rs_data),
    .rf_rt_data   (rf_rt_data),
    .ex_wr_addr   (ex_wr_addr),
    .ex_wr_en     (ex_wr_en),
    .ex_is_load   (ex_is_load),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_is_load  (mem_is_load),
    .mem_wr_data  (mem_wr_data),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4),
    .id_rs_val    (id_rs_val),
    .id_rt_val    (id_rt_val),
    .id_bubble    (id_bubble),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [31:0] instr, logic [31:0] pc4, logic [31:0] rsd, logic [31:0] rtd,
    logic [4:0] ex_a, logic ex_en, logic ex_ld,
    logic [4:0] mem_a, logic mem_en, logic mem_ld, logic [31:0] mem_d,
    logic e_stall, logic e_br, logic e_nsel, logic e_cmp,
    logic [31:0] e_npc, logic [31:0] e_rsv, logic [31:0] e_rtv);
    vec_t v;
    v.instr = instr; v.pc4 = pc4; v.rsd = rsd; v.rtd = rtd;
    v.ex_a = ex_a; v.ex_en = ex_en; v.ex_ld = ex_ld;
    v.mem_a = mem_a; v.mem_en = mem_en; v.mem_ld = mem_ld; v.mem_d = mem_d;
    v.e_stall = e_stall; v.e_br = e_br; v.e_nsel = e_nsel; v.e_cmp = e_cmp;
    v.e_npc = e_npc; v.e_rsv = e_rsv; v.e_rtv = e_rtv;
    return v;
  endfunction

  task automatic clear_hazards();
    ex_wr_addr = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_addr = '0; mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_data = '0;
  endtask

  // Capture an instruction into IF/ID with no hazard sources active
  task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
    clear_hazards();
    fw.if_instr = instr;
    fw.if_pc4   = pc4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] beq12, bne12, jmp, jal_i, jr5, add433, beq00;
    beq12  = 32'h1022_0003;
    bne12  = 32'h1422_FFFF;
    jmp    = 32'h0800_0C02;
    jal_i  = 32'h0C00_0C02;
    jr5    = 32'h00A0_0008;
    add433 = 32'h0063_2020;
    beq00  = 32'h1000_0001;

    vecs[0]  = mk(beq12, 32'h3004, 5, 5, 0,0,0, 0,0,0,0, 0,1,0,1, 32'h3010, 5, 5);
    vecs[1]  = mk(beq12, 32'h3004, 5, 6, 0,0,0, 0,0,0,0, 0,1,0,0, 32'h3010, 5, 6);
    vecs[2]  = mk(bne12, 32'h3004, 5, 6, 0,0,0, 0,0,0,0, 0,1,0,1, 32'h3000, 5, 6);
    vecs[3]  = mk(bne12, 32'h3004, 5, 5, 0,0,0, 0,0,0,0, 0,1,0,0, 32'h3000, 5, 5);
    vecs[4]  = mk(jmp,   32'h3008, 1, 2, 0,0,0, 0,0,0,0, 0,1,1,0, 32'h3008, 0, 0);
    vecs[5]  = mk(jal_i, 32'h9000_0004, 1, 2, 0,0,0, 0,0,0,0, 0,1,1,0, 32'h9000_3008, 0, 0);
    vecs[6]  = mk(jr5,   32'h3000, 32'h1234, 32'h99, 0,0,0, 0,0,0,0, 0,1,1,0, 32'h1234, 32'h1234, 0);
    vecs[7]  = mk(add433, 32'h3010, 32'h11, 32'h22, 3,1,1, 0,0,0,0, 1,0,0,0, 0, 32'h11, 32'h22);
    vecs[8]  = mk(beq00, 32'h3010, 32'hDEAD, 32'hBEEF, 0,1,0, 0,0,0,0, 0,1,0,1, 32'h3014, 0, 0);
    vecs[9]  = mk(beq12, 32'h3004, 5, 5, 2,1,0, 0,0,0,0, 1,1,0,1, 32'h3010, 5, 5);
    vecs[10] = mk(beq12, 32'h3004, 5, 5, 0,0,0, 1,1,1,32'h77, 1,1,0,1, 32'h3010, 5, 5);
    vecs[11] = mk(add433, 32'h3010, 32'h11, 32'h22, 0,0,0, 3,1,0,32'h55, !FWD,0,0,0, 0,
                  FWD ? 32'h55 : 32'h11, FWD ? 32'h55 : 32'h22);
    vecs[12] = mk(jr5, 32'h3000, 32'h100, 0, 0,0,0, 5,1,0,32'h7, !FWD,1,1,0,
                  FWD ? 32'h7 : 32'h100, FWD ? 32'h7 : 32'h100, 0);
    vecs[13] = mk(add433, 32'h3010, 32'h11, 32'h22, 3,1,0, 0,0,0,0, !FWD,0,0,0, 0, 32'h11, 32'h22);
    vecs[14] = mk(add433, 32'h3010, 32'h11, 32'h22, 3,0,1, 0,0,0,0, 0,0,0,0, 0, 32'h11, 32'h22);

    reset = 1'b1;
    clear_hazards();
    rf_rs_data = '0; rf_rt_data = '0;
    fw.if_instr = '0; fw.if_pc4 = '0;

    // Asynchronous reset takes effect before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("reset_id_instr", id_instr, 32'h0);
    chk("reset_stall", 32'(fw.Stall), 0);
    chk("reset_branch", 32'(fw.Branch), 0);
    chk("reset_cmpout", 32'(fw.CMPout), 0);
    chk("reset_cnt", 32'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven decode/hazard vectors via scoreboard queue
    for (int i = 0; i < 15; i++) begin
      vec_t v, e;
      v = vecs[i];
      load(v.instr, v.pc4);
      rf_rs_data = v.rsd; rf_rt_data = v.rtd;
      ex_wr_addr = v.ex_a; ex_wr_en = v.ex_en; ex_is_load = v.ex_ld;
      mem_wr_addr = v.mem_a; mem_wr_en = v.mem_en; mem_is_load = v.mem_ld; mem_wr_data = v.mem_d;
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_stall", i), 32'(fw.Stall), 32'(e.e_stall));
      chk($sformatf("v%0d_bubble", i), 32'(id_bubble), 32'(e.e_stall));
      chk($sformatf("v%0d_branch", i), 32'(fw.Branch), 32'(e.e_br));
      chk($sformatf("v%0d_npcsel", i), 32'(fw.NPCsel), 32'(e.e_nsel));
      chk($sformatf("v%0d_cmpout", i), 32'(fw.CMPout), 32'(e.e_cmp));
      if (e.e_br) chk($sformatf("v%0d_nextpc", i), fw.nextPC, e.e_npc);
      chk($sformatf("v%0d_rsval", i), id_rs_val, e.e_rsv);
      chk($sformatf("v%0d_rtval", i), id_rt_val, e.e_rtv);
      chk($sformatf("v%0d_id_instr", i), id_instr, e.e_stall ? 32'h0 : e.instr);
      chk($sformatf("v%0d_id_pc4", i), id_pc4, e.pc4);
      chk($sformatf("v%0d_rs_addr", i), 32'(rs_addr), 32'(e.instr[25:21]));
      chk($sformatf("v%0d_rt_addr", i), 32'(rt_addr), 32'(e.instr[20:16]));
    end

    // Delay slot: jump in IF/ID, next edge captures the slot instruction
    load(jmp, 32'h3008);
    chk("ds_npcsel", 32'(fw.NPCsel), 1);
    chk("ds_nextpc", fw.nextPC, 32'h3008);
    fw.if_instr = add433;
    fw.if_pc4   = 32'h300C;
    @(posedge clk);
    #1;
    chk("ds_slot_instr", id_instr, add433);
    chk("ds_slot_pc4", id_pc4, 32'h300C);
    chk("ds_slot_branch", 32'(fw.Branch), 0);

    // Reset asserted mid-stall clears IF/ID and counter at once
    load(add433, 32'h3010);
    ex_wr_addr = 5'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_id_instr", id_instr, 32'h0);
    chk("rst_mid_stall", 32'(fw.Stall), 0);
    chk("rst_mid_branch", 32'(fw.Branch), 0);
    chk("rst_mid_cnt", 32'(stall_cycles), 0);
    chk("rst_mid_pc4", id_pc4, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    clear_hazards();
    fw.if_instr = beq12;
    fw.if_pc4   = 32'h3004;
    @(posedge clk);
    #1;
    chk("rst_rel_load", id_instr, beq12);
    chk("rst_rel_branch", 32'(fw.Branch), 1);

    // Load-use: one bubble, IF/ID held, counter advances by one
    load(add433, 32'h3010);
    fw.if_instr = beq00;
    ex_wr_addr = 5'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    #1;
    chk("lu_stall", 32'(fw.Stall), 1);
    chk("lu_cnt0", 32'(stall_cycles), 0);
    @(posedge clk);
    #1;
    chk("lu_cnt1", 32'(stall_cycles), 1);
    chk("lu_bubble_instr", id_instr, 32'h0);
    clear_hazards();
    #1;
    chk("lu_held_instr", id_instr, add433);
    chk("lu_held_pc4", id_pc4, 32'h3010);
    chk("lu_release", 32'(id_bubble), 0);

    // Counter saturation: hold a stall well past 2^16 cycles
    ex_wr_addr = 5'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_near", 32'(stall_cycles), 32'hFFFE);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_top", 32'(stall_cycles), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(stall_cycles), 32'hFFFF);
    chk("sat_instr_held", dut.id_pc4, 32'h3010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
